// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART packet sender.
// Used by uart_frame_sender and tx_byte_handshake.
package uart_frame_pkg;

    localparam int         LEN_W    = 16;
    localparam logic [7:0] HDR0_DEF = 8'hAA;
    localparam logic [7:0] HDR1_DEF = 8'h55;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_ACT,
        WAIT_DONE,
        WAIT_GAP,
        FETCH,
        CAPTURE,
        FINISH
    } state_t;

    // Which part of the frame the sequencer is currently emitting.
    typedef enum logic [1:0] {
        PH_HDR,
        PH_PAY,
        PH_CSUM
    } phase_t;

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte handshake with uart_tx: latch byte, issue dv when the transmitter is idle,
// then track active -> done -> fully idle before reporting the byte as sent.
module tx_byte_handshake
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_byte_sent,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (i_load && (r_state == IDLE)) begin
                r_byte <= i_byte;
            end
        end
    end

    // uart_tx keeps done high for two cycles and drops dv outside its idle state,
    // so the gap state waits for both flags low before the next byte may go out.
    always_comb begin
        w_state_next = r_state;
        o_tx_dv      = 1'b0;
        o_byte_sent  = 1'b0;
        case (r_state)
            IDLE:      if (i_load) w_state_next = ISSUE;
            ISSUE: begin
                if (!i_tx_active && !i_tx_done) begin
                    o_tx_dv      = 1'b1;
                    w_state_next = WAIT_ACT;
                end
            end
            WAIT_ACT:  if (i_tx_active) w_state_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done) w_state_next = WAIT_GAP;
            WAIT_GAP: begin
                if (!i_tx_done && !i_tx_active) begin
                    o_byte_sent  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default:   w_state_next = IDLE;
        endcase
    end

    assign o_tx_byte = r_byte;

endmodule

// File: rtl/uart_frame_sender.sv
// Streams one framed packet (AA 55 LEN_HI LEN_LO payload [checksum]) per start request.
// Define UART_FRAME_CHECKSUM_EN to append the modulo-256 checksum byte.
module uart_frame_sender
    import uart_frame_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 320,
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_aborted,
    output logic       o_stall,
    output logic       o_fifo_rd,
    input  logic [7:0] i_fifo_data,
    input  logic       i_fifo_empty,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done
);

    localparam logic [LEN_W-1:0] LEN_VAL  = LEN_W'(PAYLOAD_LEN);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(PAYLOAD_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    phase_t           r_phase;
    logic [1:0]       r_hdr_idx;
    logic [LEN_W-1:0] r_pay_cnt;
    logic             r_abort;
    logic             w_abort;
    logic             w_load;
    logic [7:0]       w_load_byte;
    logic [7:0]       w_hdr_byte;
    logic [7:0]       w_seq_byte;
    logic             w_byte_sent;

    assign w_abort = r_abort | i_abort;
    assign o_busy  = (r_state != IDLE) && (r_state != FINISH);

    always_comb begin
        case (r_hdr_idx)
            2'd0:    w_hdr_byte = HDR0;
            2'd1:    w_hdr_byte = HDR1;
            2'd2:    w_hdr_byte = LEN_VAL[15:8];
            default: w_hdr_byte = LEN_VAL[7:0];
        endcase
    end

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] r_csum;

    // Sum covers LEN_HI, LEN_LO and every payload byte, not the sync bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if ((r_state == IDLE) && i_start) begin
            r_csum <= 8'h00;
        end else if (w_load && ((r_state == CAPTURE) ||
                                ((r_phase == PH_HDR) && r_hdr_idx[1]))) begin
            r_csum <= r_csum + w_load_byte;
        end
    end

    assign w_seq_byte = (r_phase == PH_CSUM) ? r_csum : w_hdr_byte;
`else
    assign w_seq_byte = w_hdr_byte;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ISSUE stands for the whole handshake; the sub-module tracks the finer phases.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_byte  = w_seq_byte;
        o_fifo_rd    = 1'b0;
        o_stall      = 1'b0;
        o_frame_done = 1'b0;
        o_aborted    = 1'b0;
        case (r_state)
            IDLE:    if (i_start) w_state_next = LOAD;
            LOAD: begin
                w_load       = 1'b1;
                w_state_next = ISSUE;
            end
            CAPTURE: begin
                w_load       = 1'b1;
                w_load_byte  = i_fifo_data;
                w_state_next = ISSUE;
            end
            ISSUE: begin
                if (w_byte_sent) begin
                    if (w_abort) begin
                        w_state_next = FINISH;
                    end else begin
                        case (r_phase)
                            PH_HDR:  w_state_next = (r_hdr_idx == 2'd3) ? FETCH : LOAD;
                            PH_PAY: begin
                                if (r_pay_cnt == LAST_IDX) begin
`ifdef UART_FRAME_CHECKSUM_EN
                                    w_state_next = LOAD;
`else
                                    w_state_next = FINISH;
`endif
                                end else begin
                                    w_state_next = FETCH;
                                end
                            end
                            default: w_state_next = FINISH;
                        endcase
                    end
                end
            end
            FETCH: begin
                if (w_abort) begin
                    w_state_next = FINISH;
                end else if (i_fifo_empty) begin
                    o_stall = 1'b1;
                end else begin
                    o_fifo_rd    = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            FINISH: begin
                o_aborted    = r_abort;
                o_frame_done = !r_abort;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase   <= PH_HDR;
            r_hdr_idx <= 2'd0;
            r_pay_cnt <= '0;
            r_abort   <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_phase   <= PH_HDR;
                    r_hdr_idx <= 2'd0;
                    r_pay_cnt <= '0;
                    r_abort   <= 1'b0;
                end
            end else if (r_state != FINISH) begin
                r_abort <= w_abort;
            end
            if ((r_state == ISSUE) && w_byte_sent) begin
                case (r_phase)
                    PH_HDR: begin
                        if (r_hdr_idx == 2'd3) r_phase <= PH_PAY;
                        else                   r_hdr_idx <= r_hdr_idx + 2'd1;
                    end
                    PH_PAY: begin
                        if (r_pay_cnt == LAST_IDX) r_phase <= PH_CSUM;
                        else                       r_pay_cnt <= r_pay_cnt + LEN_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    tx_byte_handshake u_handshake (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_byte      (w_load_byte),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done),
        .o_byte_sent (w_byte_sent),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte)
    );

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender with a uart_tx timing model (4 clocks/bit) and a FIFO model.
// Expected frame bytes are hand-computed constants; UART_FRAME_CHECKSUM_EN adds the 0x0E trailer.
module tb_uart_frame_sender;

    localparam int PLEN = 4;
    localparam int CPB  = 4;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int EXP_LEN = 9;
`else
    localparam int EXP_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, frame_done, aborted, stall, fifo_rd, tx_dv;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;

    int tests_run = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_frame_sender #(.PAYLOAD_LEN(PLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_aborted    (aborted),
        .o_stall      (stall),
        .o_fifo_rd    (fifo_rd),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_tx_dv      (tx_dv),
        .o_tx_byte    (tx_byte),
        .i_tx_active  (tx_active),
        .i_tx_done    (tx_done)
    );

    // FIFO model: data appears the cycle after the read strobe.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       fifo_flush = 1'b0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // uart_tx model: active for 10 bit times, then done high for two cycles; not reset.
    int m_st = 0;
    int m_cnt = 0;
    always @(posedge clk) begin
        case (m_st)
            0: begin
                tx_done <= 1'b0;
                if (tx_dv) begin
                    tx_active <= 1'b1;
                    m_cnt     <= 0;
                    m_st      <= 1;
                end
            end
            1: begin
                if (m_cnt == 10 * CPB - 1) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                    m_st      <= 2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            default: begin
                tx_done <= 1'b1;
                m_st    <= 0;
            end
        endcase
    end

    // Event monitor, sampled on the falling edge.
    logic [7:0] sent_mem [0:255];
    int n_sent = 0, n_rd = 0, n_done = 0, n_abt = 0, n_viol = 0;
    always @(negedge clk) begin
        if (tx_dv) begin
            sent_mem[n_sent] <= tx_byte;
            n_sent           <= n_sent + 1;
        end
        if (fifo_rd)    n_rd   <= n_rd + 1;
        if (frame_done) n_done <= n_done + 1;
        if (aborted)    n_abt  <= n_abt + 1;
        if ((fifo_rd && fifo_empty) || (stall && (fifo_rd || tx_dv)) ||
            (tx_dv && (tx_active || tx_done)))
            n_viol <= n_viol + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(tx_dv && (tx_active || tx_done)))
                else $error("dv issued while uart_tx not idle");
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        case (i)
            0:       return 8'hAA;
            1:       return 8'h55;
            2:       return 8'h00;
            3:       return 8'h04;
            4:       return 8'h01;
            5:       return 8'h02;
            6:       return 8'h03;
            7:       return 8'h04;
            default: return 8'h0E;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push4();
        for (int i = 1; i <= 4; i++) push(8'(i));
    endtask

    task automatic flush();
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok, output bit busy_low);
        ok = 1'b0;
        busy_low = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (frame_done || aborted) begin
                ok = 1'b1;
                busy_low = !busy;
                break;
            end
        end
        tick(3);
    endtask

    task automatic wait_dv_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (tx_dv && (tx_byte == b)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        tests_run++;
        if ({busy, frame_done, aborted, stall, fifo_rd, tx_dv, tx_byte} !== 14'h0) begin
            failed++;
            $display("FAIL reset_outputs: got %b want 0", {busy, frame_done, aborted, stall, fifo_rd, tx_dv, tx_byte});
        end
        reset = 1'b0;
        tick(2);
        tests_run++;
        if ({busy, stall, fifo_rd, tx_dv} !== 4'h0) begin
            failed++;
            $display("FAIL idle_outputs: got %b want 0000", {busy, stall, fifo_rd, tx_dv});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_normal_frame();
        int bs, br, bd, ba, bv, lat;
        bit ok, bl;
        push4();
        bs = n_sent; br = n_rd; bd = n_done; ba = n_abt; bv = n_viol;
        pulse_start();
        tests_run++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        lat = 1;
        while (!tx_dv && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (lat !== 2) begin
            failed++;
            $display("FAIL start_latency: got %0d want 2", lat);
        end
        wait_end(ok, bl);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL normal_timeout: no end of frame within budget");
        end
        tests_run++;
        if (!bl) begin
            failed++;
            $display("FAIL busy_at_done: busy still high on done pulse");
        end
        tests_run++;
        if ((n_done - bd) !== 1 || (n_abt - ba) !== 0) begin
            failed++;
            $display("FAIL normal_pulses: done %0d aborted %0d want 1 0", n_done - bd, n_abt - ba);
        end
        tests_run++;
        if ((n_rd - br) !== 4) begin
            failed++;
            $display("FAIL normal_reads: got %0d want 4", n_rd - br);
        end
        tests_run++;
        if ((n_sent - bs) !== EXP_LEN) begin
            failed++;
            $display("FAIL normal_len: got %0d want %0d", n_sent - bs, EXP_LEN);
        end
        for (int i = 0; i < EXP_LEN; i++) begin
            tests_run++;
            if (sent_mem[bs + i] !== exp_byte(i)) begin
                failed++;
                $display("FAIL normal_byte[%0d]: got %02h want %02h", i, sent_mem[bs + i], exp_byte(i));
            end
        end
        tests_run++;
        if (n_viol !== bv) begin
            failed++;
            $display("FAIL normal_protocol: %0d violations want 0", n_viol - bv);
        end
        $display("[TB] normal frame: %0d bytes, %0d reads", n_sent - bs, n_rd - br);
    endtask

    task automatic test_stall();
        int bs, br, bd, bv, st_hi, act;
        bit ok, bl;
        push(8'h01);
        push(8'h02);
        bs = n_sent; br = n_rd; bd = n_done; bv = n_viol;
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (stall) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL stall_timeout: stall never raised");
        end
        st_hi = 0;
        act = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stall) st_hi++;
            if (fifo_rd || tx_dv) act++;
        end
        tests_run++;
        if (st_hi !== 200 || act !== 0) begin
            failed++;
            $display("FAIL stall_gap: stall cycles %0d rd/dv %0d want 200 0", st_hi, act);
        end
        tests_run++;
        if ((n_rd - br) !== 2) begin
            failed++;
            $display("FAIL stall_reads_before: got %0d want 2", n_rd - br);
        end
        push(8'h03);
        push(8'h04);
        wait_end(ok, bl);
        tests_run++;
        if (!ok || (n_done - bd) !== 1 || (n_rd - br) !== 4) begin
            failed++;
            $display("FAIL stall_complete: ended %b done %0d reads %0d want 1 1 4", ok, n_done - bd, n_rd - br);
        end
        for (int i = 0; i < EXP_LEN; i++) begin
            tests_run++;
            if (sent_mem[bs + i] !== exp_byte(i)) begin
                failed++;
                $display("FAIL stall_byte[%0d]: got %02h want %02h", i, sent_mem[bs + i], exp_byte(i));
            end
        end
        tests_run++;
        if (n_viol !== bv) begin
            failed++;
            $display("FAIL stall_protocol: %0d violations want 0", n_viol - bv);
        end
        $display("[TB] stalled frame: %0d bytes, stall %0d cycles", n_sent - bs, st_hi);
    endtask

    task automatic test_abort();
        int bs, br, bd, ba;
        bit ok, bl;
        push4();
        push(8'h05);
        push(8'h06);
        bs = n_sent; br = n_rd; bd = n_done; ba = n_abt;
        pulse_start();
        wait_dv_byte(8'h03, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL abort_timeout: third payload byte never issued");
        end
        tick(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end(ok, bl);
        tick(80);
        tests_run++;
        if (!ok || (n_abt - ba) !== 1 || (n_done - bd) !== 0) begin
            failed++;
            $display("FAIL abort_pulses: ended %b aborted %0d done %0d want 1 1 0", ok, n_abt - ba, n_done - bd);
        end
        tests_run++;
        if ((n_rd - br) !== 3) begin
            failed++;
            $display("FAIL abort_reads: got %0d want 3", n_rd - br);
        end
        tests_run++;
        if ((n_sent - bs) !== 7) begin
            failed++;
            $display("FAIL abort_len: got %0d want 7", n_sent - bs);
        end
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (sent_mem[bs + i] !== exp_byte(i)) begin
                failed++;
                $display("FAIL abort_byte[%0d]: got %02h want %02h", i, sent_mem[bs + i], exp_byte(i));
            end
        end
        flush();
        $display("[TB] aborted frame: %0d bytes, %0d reads", n_sent - bs, n_rd - br);
    endtask

    task automatic test_start_abort_same();
        int bs, bd, ba;
        bit ok, bl;
        push4();
        bs = n_sent; bd = n_done; ba = n_abt;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        wait_end(ok, bl);
        tests_run++;
        if (!ok || (n_done - bd) !== 1 || (n_abt - ba) !== 0 || (n_sent - bs) !== EXP_LEN) begin
            failed++;
            $display("FAIL start_abort_same: ended %b done %0d aborted %0d bytes %0d want 1 1 0 %0d",
                     ok, n_done - bd, n_abt - ba, n_sent - bs, EXP_LEN);
        end
        $display("[TB] start+abort frame: %0d bytes", n_sent - bs);
    endtask

    task automatic test_back_to_back_start();
        int bs, br, bd;
        bit ok, bl;
        push4();
        bs = n_sent; br = n_rd; bd = n_done;
        pulse_start();
        tick(20);
        pulse_start();
        tick(100);
        pulse_start();
        wait_end(ok, bl);
        tick(100);
        tests_run++;
        if (!ok || (n_done - bd) !== 1) begin
            failed++;
            $display("FAIL busy_start_done: ended %b done %0d want 1 1", ok, n_done - bd);
        end
        tests_run++;
        if ((n_sent - bs) !== EXP_LEN || (n_rd - br) !== 4) begin
            failed++;
            $display("FAIL busy_start_ignored: bytes %0d reads %0d want %0d 4", n_sent - bs, n_rd - br, EXP_LEN);
        end
        $display("[TB] start-while-busy frame: %0d bytes", n_sent - bs);
    endtask

    task automatic test_reset_mid();
        int bs, br, bd;
        bit ok, bl;
        push4();
        br = n_rd;
        pulse_start();
        wait_dv_byte(8'h55, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL reset_mid_timeout: HDR1 never issued");
        end
        tick(5);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, frame_done, aborted, stall, fifo_rd, tx_dv, tx_byte} !== 14'h0) begin
            failed++;
            $display("FAIL reset_mid_outputs: got %b want 0", {busy, frame_done, aborted, stall, fifo_rd, tx_dv, tx_byte});
        end
        reset = 1'b0;
        tick(2);
        tests_run++;
        if ((n_rd - br) !== 0) begin
            failed++;
            $display("FAIL reset_mid_reads: got %0d want 0", n_rd - br);
        end
        bs = n_sent; bd = n_done;
        pulse_start();
        wait_end(ok, bl);
        tests_run++;
        if (!ok || (n_done - bd) !== 1 || (n_sent - bs) !== EXP_LEN) begin
            failed++;
            $display("FAIL reset_mid_frame: ended %b done %0d bytes %0d want 1 1 %0d", ok, n_done - bd, n_sent - bs, EXP_LEN);
        end
        for (int i = 0; i < EXP_LEN; i++) begin
            tests_run++;
            if (sent_mem[bs + i] !== exp_byte(i)) begin
                failed++;
                $display("FAIL reset_mid_byte[%0d]: got %02h want %02h", i, sent_mem[bs + i], exp_byte(i));
            end
        end
        $display("[TB] post-reset frame: %0d bytes", n_sent - bs);
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_stall();
        test_abort();
        test_start_abort_same();
        test_back_to_back_start();
        test_reset_mid();
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
Name: uart_frame_sender

Overview:
- Sequences the serial transmitter (uart_tx) to stream one framed packet of camera bytes per start request.
- Frame on the wire: 0xAA, 0x55, LEN_HI, LEN_LO, PAYLOAD_LEN payload bytes pulled from the pixel FIFO, then an optional checksum byte.
- Sits between the OV7670 capture FIFO read port and uart_tx; the host resyncs on the 0xAA 0x55 header.

Parameters:
- PAYLOAD_LEN, 320, payload bytes per frame; legal range 1..65535.
- HDR0, 8'hAA, first sync byte.
- HDR1, 8'h55, second sync byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request to send one frame; ignored while o_busy=1
- i_abort  in  1  level/pulse; ends the frame early, after the byte currently in flight completes
- o_busy  out  1  high from the cycle after an accepted i_start until the return to IDLE
- o_frame_done  out  1  one-cycle pulse; frame completed normally
- o_aborted  out  1  one-cycle pulse; frame ended by i_abort
- o_stall  out  1  high while a payload byte is due and i_fifo_empty=1
- o_fifo_rd  out  1  one-cycle FIFO read strobe
- i_fifo_data  in  8  FIFO read data, valid the cycle after o_fifo_rd
- i_fifo_empty  in  1  FIFO empty flag
- o_tx_dv  out  1  one-cycle byte-valid pulse to uart_tx i_Tx_Dv
- o_tx_byte  out  8  byte to uart_tx i_Tx_Byte; held stable from o_tx_dv until the next load
- i_tx_active  in  1  from uart_tx o_Tx_Active
- i_tx_done  in  1  from uart_tx o_Tx_Done

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, checksum 0.
- Reset mid-frame returns to IDLE immediately. A byte already in flight in uart_tx still completes; the partial frame is recovered by the host header search.
- States: IDLE, LOAD, ISSUE, WAIT_ACT, WAIT_DONE, WAIT_GAP, FETCH, CAPTURE, FINISH.
- Byte sequencer:
  - Each byte is loaded into o_tx_byte in LOAD or CAPTURE, then goes to ISSUE.
  - ISSUE asserts o_tx_dv for exactly one cycle, only when i_tx_active=0 and i_tx_done=0; otherwise it waits in ISSUE.
  - WAIT_ACT waits for i_tx_active=1.
  - WAIT_DONE waits for i_tx_done=1.
  - WAIT_GAP waits until i_tx_done=0 and i_tx_active=0. uart_tx holds done for 2 cycles and ignores dv outside its idle state, so no dv may be issued earlier.
- Sequence index selects the byte: HDR0, HDR1, PAYLOAD_LEN[15:8], PAYLOAD_LEN[7:0], then payload.
- Payload byte path:
  - FETCH with i_fifo_empty=0: pulse o_fifo_rd and go to CAPTURE.
  - FETCH with i_fifo_empty=1: o_stall=1 and wait indefinitely.
  - CAPTURE latches i_fifo_data into o_tx_byte, then goes to ISSUE.
  - Exactly one o_fifo_rd per payload byte; never a read while empty.
- Payload counter is 16-bit and counts 0..PAYLOAD_LEN-1; no wrap.
- After the last payload byte's WAIT_GAP, go to the checksum byte (macro on) or to FINISH.
- FINISH: pulse o_frame_done (or o_aborted) and go to IDLE. o_busy falls the same cycle o_frame_done pulses.
- Abort:
  - i_abort is sampled each cycle while busy and sets a sticky abort flag.
  - At the next WAIT_GAP exit or FETCH, go to FINISH with o_aborted instead of o_frame_done.
  - Abort from FETCH performs no further o_fifo_rd.
  - i_start and i_abort in the same IDLE cycle: start wins, and the abort is ignored.
- Minimum start-to-first-dv latency: 2 cycles (IDLE -> LOAD -> ISSUE).

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- Defined:
  - An 8-bit checksum accumulates as the modulo-256 sum of LEN_HI, LEN_LO and all payload bytes.
  - It is sent as one extra byte after the payload.
  - It is cleared on start and on reset.
  - It is not sent if the frame is aborted.
- Undefined: no checksum register; the frame ends after the payload.

Decomposition:
- Package uart_frame_pkg: state enum, HDR0/HDR1 defaults, LEN_W=16 constant.
- One natural sub-module, tx_byte_handshake: implements ISSUE/WAIT_ACT/WAIT_DONE/WAIT_GAP with inputs load, byte, i_tx_active, i_tx_done and output byte_sent.

Test Plan (uart_tx with CLKS_PER_BIT=4, PAYLOAD_LEN=4):
- FIFO preloaded 01 02 03 04, pulse i_start -> serial decodes AA 55 00 04 01 02 03 04 [+ 0E with macro]; exactly 4 o_fifo_rd pulses; one o_frame_done pulse.
- FIFO empty after 2 bytes, refilled 200 cycles later -> o_stall high throughout the gap, no rd while empty, no dv during stall; the frame completes correctly.
- i_abort during the third payload byte -> that byte finishes, no further rd/dv, o_aborted pulses once, and no checksum byte is sent.
- i_start pulsed while busy -> ignored; exactly one frame is transmitted.
- reset asserted during HDR1 -> all outputs 0 next cycle; a new start afterwards yields a clean, complete frame.
- Over the whole run -> o_tx_dv is never high while i_tx_active or i_tx_done is high (assertion).
